// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: owner encoding and the
// read-response tag record used by the core and its tag pipeline.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

   // Starve counter width: wide enough for STARVE_MAX, never below 3 bits.
   function automatic int unsigned starve_w(input int unsigned smax);
      int unsigned w;
      w = unsigned'($clog2(smax + 1));
      return (w > 3) ? w : 3;
   endfunction

endpackage

// File: rtl/mem_arb_tagpipe.sv
// LAT-deep shift register of read-owner tags; the oldest tag marks which port
// owns the memory read data arriving this cycle.
module mem_arb_tagpipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tag_valid_i,
   input  logic tag_owner_i,
   output logic tag_valid_o,
   output logic tag_owner_o
);

   tag_t tag_in;
   tag_t pipe_q [LAT];

   assign tag_in = '{valid: tag_valid_i, owner: owner_e'(tag_owner_i)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_in;
         for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_valid_o = pipe_q[LAT-1].valid;
   assign tag_owner_o = pipe_q[LAT-1].owner;

endmodule

// File: rtl/mem_arb.sv
// Two-port (fetch/data) single-memory arbiter with pipelined read-response routing.
// Define MEM_ARB_STARVATION_GUARD_EN to force a fetch grant after STARVE_MAX refusals.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned LAT        = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   logic gnt_if_c;
   logic gnt_dm_c;
   logic rd_gnt_c;
   logic tag_valid;
   logic tag_owner;

`ifdef MEM_ARB_STARVATION_GUARD_EN
   localparam int unsigned SW = starve_w(STARVE_MAX);

   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;
   logic          force_if_c;

   assign force_if_c = if_req_i && (starve_q == SW'(STARVE_MAX));

   always_comb begin
      gnt_dm_c = dm_req_i && !force_if_c;
      gnt_if_c = if_req_i && !gnt_dm_c;
   end

   // Count consecutive cycles the fetch port was refused, saturating.
   always_comb begin
      starve_d = '0;
      if (if_req_i && !gnt_if_c) begin
         starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`else
   always_comb begin
      gnt_dm_c = dm_req_i;
      gnt_if_c = if_req_i && !dm_req_i;
   end
`endif

   assign rd_gnt_c = (gnt_dm_c && !dm_we_i) || gnt_if_c;

   mem_arb_tagpipe #(
      .LAT (LAT)
   ) u_tagpipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .tag_valid_i (rd_gnt_c),
      .tag_owner_i (gnt_dm_c),
      .tag_valid_o (tag_valid),
      .tag_owner_o (tag_owner)
   );

   // Grant and memory strobe follow the current owner in the same cycle.
   always_comb begin
      if_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (rst_n) begin
         if (gnt_dm_c) begin
            dm_gnt_o    = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = dm_we_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
         end else if (gnt_if_c) begin
            if_gnt_o   = 1'b1;
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i;
         end
      end
   end

   // Route returning read data to the port recorded LAT cycles ago.
   always_comb begin
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_rvalid_o = 1'b0;
      dm_rdata_o  = '0;
      if (rst_n && tag_valid) begin
         if (tag_owner == 1'(OWN_DM)) begin
            dm_rvalid_o = 1'b1;
            dm_rdata_o  = mem_rdata_i;
         end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: one LAT=1 and one LAT=3 instance share stimulus; a
// cycle-indexed response scoreboard predicts grants and routed read data.
module tb_mem_arb;

   localparam int unsigned STARVE_MAX = 4;
   localparam int MAXC = 1024;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;

   logic        if_gnt    [2];
   logic        if_rvalid [2];
   logic [31:0] if_rdata  [2];
   logic        dm_gnt    [2];
   logic        dm_rvalid [2];
   logic [31:0] dm_rdata  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   int cmps = 0;
   int errs = 0;
   int cyc  = 0;
   int sc   = 0;

   logic        ev [2][MAXC];
   logic        eo [2][MAXC];
   logic [31:0] ed [2][MAXC];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   mem_arb #(.LAT(1), .STARVE_MAX(STARVE_MAX)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr),
      .if_gnt_o(if_gnt[0]), .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_gnt_o(dm_gnt[0]), .dm_rvalid_o(dm_rvalid[0]), .dm_rdata_o(dm_rdata[0]),
      .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
      .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
   );

   mem_arb #(.LAT(3), .STARVE_MAX(STARVE_MAX)) u_l3 (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr),
      .if_gnt_o(if_gnt[1]), .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_gnt_o(dm_gnt[1]), .dm_rvalid_o(dm_rvalid[1]), .dm_rdata_o(dm_rdata[1]),
      .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
      .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: read data appears LAT cycles after a read strobe, junk otherwise.
   logic [31:0] p1;
   logic [31:0] p3 [3];
   always_ff @(posedge clk) begin
      p1    <= (mem_en[0] && !mem_we[0]) ? memf(mem_addr[0]) : 32'hBAD0_BAD0;
      p3[0] <= (mem_en[1] && !mem_we[1]) ? memf(mem_addr[1]) : 32'hBAD3_BAD3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_rdata[0] = p1;
   assign mem_rdata[1] = p3[2];

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s inst=L%0d cyc=%0d observed=%h expected=%h", tag, (k == 0) ? 1 : 3, cyc, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic do_cycle(output logic gi_o, output logic gd_o);
      logic force_if, gi, gd;
      logic rv_if, rv_dm;
      logic [31:0] rd_if, rd_dm;
      if (cyc + 5 >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      @(negedge clk);
      force_if = 1'b0;
`ifdef MEM_ARB_STARVATION_GUARD_EN
      force_if = if_req && (sc >= int'(STARVE_MAX));
`endif
      gd = rst_n && dm_req && !force_if;
      gi = rst_n && if_req && !gd;
      for (int k = 0; k < 2; k++) begin
         rv_if = rst_n && ev[k][cyc] && !eo[k][cyc];
         rv_dm = rst_n && ev[k][cyc] &&  eo[k][cyc];
         rd_if = rv_if ? ed[k][cyc] : 32'h0;
         rd_dm = rv_dm ? ed[k][cyc] : 32'h0;
         chk("if_gnt",    k, 32'(if_gnt[k]), 32'(gi));
         chk("dm_gnt",    k, 32'(dm_gnt[k]), 32'(gd));
         chk("mem_en",    k, 32'(mem_en[k]), 32'(gi || gd));
         chk("mem_we",    k, 32'(mem_we[k]), 32'(gd && dm_we));
         chk("mem_addr",  k, mem_addr[k],  gd ? dm_addr : (gi ? if_addr : 32'h0));
         chk("mem_wdata", k, mem_wdata[k], gd ? dm_wdata : 32'h0);
         chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(rv_if));
         chk("if_rdata",  k, if_rdata[k], rd_if);
         chk("dm_rvalid", k, 32'(dm_rvalid[k]), 32'(rv_dm));
         chk("dm_rdata",  k, dm_rdata[k], rd_dm);
      end
      if (!rst_n) begin
         for (int k = 0; k < 2; k++)
            for (int j = cyc; j < cyc + 5; j++) ev[k][j] = 1'b0;
         sc = 0;
      end else begin
         if ((gd && !dm_we) || gi) begin
            for (int k = 0; k < 2; k++) begin
               ev[k][cyc + ((k == 0) ? 1 : 3)] = 1'b1;
               eo[k][cyc + ((k == 0) ? 1 : 3)] = gd;
               ed[k][cyc + ((k == 0) ? 1 : 3)] = memf(gd ? dm_addr : if_addr);
            end
         end
         if (if_req && !gi) sc = (sc < int'(STARVE_MAX)) ? sc + 1 : sc;
         else               sc = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      gi_o = gi;
      gd_o = gd;
   endtask

   task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
      logic gi, gd;
      if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
      do_cycle(gi, gd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      step(1'b1, 32'h44, 1'b1, 1'b0, 32'h88, 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic gi, gd;
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < MAXC; j++) begin
            ev[k][j] = 1'b0; eo[k][j] = 1'b0; ed[k][j] = 32'h0;
         end
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

      // Outputs stay quiet in reset even with requests pending.
      step(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h1234);
      step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b1;
      idle(1);

      // Fetch-only pipelined reads.
      step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(4);

      // Contention: data wins, fetch follows.
      step(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(4);

      // Write produces no response.
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
      idle(4);

      // Interleaved owners; responses in grant order.
      step(1'b0, 32'h0,   1'b1, 1'b0, 32'h300, 32'h0);
      step(1'b1, 32'h304, 1'b0, 1'b0, 32'h0,   32'h0);
      step(1'b0, 32'h0,   1'b1, 1'b0, 32'h308, 32'h0);
      idle(4);

      // Sustained contention: starvation guard behaviour.
      for (int i = 0; i < 6; i++) step(1'b1, 32'h500, 1'b1, 1'b0, 32'h600 + 32'(i * 4), 32'h0);
      idle(4);

      // Reset while reads are in flight.
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0);
      reset_pulse();
      idle(5);
      step(1'b1, 32'h704, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(4);

      // Random traffic; requesters hold payload until granted.
      gi = 1'b1; gd = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (!if_req || gi) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 32'($urandom_range(0, 1023)) << 2;
         end
         if (!dm_req || gd) begin
            dm_req   = ($urandom_range(0, 1) != 0);
            dm_we    = ($urandom_range(0, 2) == 0);
            dm_addr  = 32'($urandom_range(0, 1023)) << 2;
            dm_wdata = $urandom;
         end
         if (n == 150) begin
            rst_n = 1'b0;
            do_cycle(gi, gd);
            rst_n = 1'b1;
            gi = 1'b1; gd = 1'b1;
         end else begin
            do_cycle(gi, gd);
         end
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter LAT, default 1, meaning: fixed memory read latency in cycles from mem_en_o to mem_rdata_i valid (legal 1..4).
REQ-002 Parameter STARVE_MAX, default 4, meaning: consecutive refused fetch cycles before fetch is forced.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req_i  input  1  fetch read request; if_addr_i  input  32  fetch byte address.
REQ-006 if_gnt_o  output  1  fetch request accepted this cycle; if_rvalid_o  output  1  if_rdata_o valid; if_rdata_o  output  32  fetch read data.
REQ-007 dm_req_i  input  1  data request; dm_we_i  input  1  write when high; dm_addr_i  input  32  byte address; dm_wdata_i  input  32  write data.
REQ-008 dm_gnt_o  output  1  data request accepted; dm_rvalid_o  output  1  dm_rdata_o valid; dm_rdata_o  output  32  data read result.
REQ-009 mem_en_o  output  1  access strobe; mem_we_o  output  1  write; mem_addr_o  output  32; mem_wdata_o  output  32; mem_rdata_i  input  32  read data, LAT cycles after a read strobe.

Function
REQ-010 Arbitration combinational in same cycle: at most one of if_gnt_o, dm_gnt_o high; a grant only when the matching req is high.
REQ-011 Default priority: data port over fetch port; fetch granted when dm_req_i low.
REQ-012 Granted request drives mem_en_o=1, mem_addr_o/mem_we_o/mem_wdata_o from owner same cycle; fetch grants force mem_we_o=0; no grant -> mem_en_o=0, mem_we_o=0, addr/wdata 0.
REQ-013 Requester holds req and payload stable until granted; arbiter keeps no request buffer.
REQ-014 Owner-tag shift register depth LAT: each cycle shifts in {valid=read granted, owner=IF/DM}; write grants shift in valid=0.
REQ-015 Tag at depth LAT valid -> owner rvalid high one cycle, owner rdata = mem_rdata_i; non-owner rdata 0, rvalid 0.
REQ-016 Writes produce no rvalid; back-to-back reads, one per cycle, fully pipelined, responses in grant order.
REQ-017 Starve counter (3+ bits, saturating at STARVE_MAX): increments when if_req_i high and if_gnt_o low; clears on if_gnt_o or if_req_i low.
REQ-018 Simultaneous grant and response same cycle to same port legal; both reported independently.

Reset
REQ-019 rst_n low: tag register cleared, starve counter 0; all outputs 0 while in reset.
REQ-020 Reset mid-operation: in-flight reads discarded; no rvalid in any cycle after rst_n deasserts until a new read is granted and LAT cycles elapse.

Configuration
REQ-021 Macro MEM_ARB_STARVATION_GUARD_EN defined: when starve counter == STARVE_MAX and if_req_i high, fetch granted over dm_req_i for that cycle, counter clears.
REQ-022 Macro undefined: strict data priority, starve counter absent; fetch may starve indefinitely.

Structure
REQ-023 Owner encoding (OWN_IF=0, OWN_DM=1) and tag record layout live in shared package mem_arb_pkg for reuse by core and bench.
REQ-024 One sub-module natural: mem_arb_tagpipe (parameterised LAT-deep tag shift register with async clear).

Verification
REQ-025 Fetch only: if_req_i=1, addr 0x0,0x4,0x8 consecutive cycles, LAT=1 -> if_gnt_o each cycle, if_rvalid_o cycles 2-4 with mem data of 0x0,0x4,0x8.
REQ-026 Contention: if_req_i=1 and dm_req_i=1 read addr 0x100 same cycle -> dm_gnt_o=1, if_gnt_o=0, mem_addr_o=0x100; next cycle fetch granted if dm_req_i low.
REQ-027 Write: dm_we_i=1, addr 0x200, wdata 0xDEADBEEF -> mem_en_o=1, mem_we_o=1, mem_wdata_o=0xDEADBEEF, no dm_rvalid_o in following 4 cycles.
REQ-028 Starvation (macro on, STARVE_MAX=4): dm_req_i and if_req_i held high -> 4 dm grants then if_gnt_o=1 on 5th cycle; macro off -> if_gnt_o stays 0.
REQ-029 LAT=3 interleave: DM read, IF read, DM read in cycles 0-2 -> rvalid on DM, IF, DM in cycles 3-5, correct data routing.
REQ-030 Reset mid-flight: read granted, rst_n pulsed low next cycle -> no rvalid on either port afterward; outputs 0 during reset.
